im_port_arbiter: RTL

Shares the single-ported 16-bit x 64K instruction memory between two requesters:
- the pipeline fetch stage, which has default ownership;
- a program-loader/debug port, which reads and writes instruction words.

The block sits between the IF stage and the instruction memory. It drives the memory address, read enable and write enable, and returns registered read data. A bounded-burst fairness rule stops the loader from starving fetch.

---
 rtl/im_port_arbiter_if.sv | 43 ++++
 rtl/im_port_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/im_port_arbiter_if.sv
// Fetch, loader and instruction-memory signal bundle
// for the instruction-memory port arbiter.
interface im_port_arbiter_if #(
  parameter int AW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [15:0]   if_instr;
  logic          if_vld;
  logic          if_stall;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_wdata;
  logic          ld_gnt;
  logic [15:0]   ld_rdata;
  logic          ld_vld;

  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_instr, if_vld, if_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rdata, ld_vld,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_instr, if_vld, if_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rdata, ld_vld,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares the single-ported instruction memory between fetch
// (default owner) and a loader port with bounded bursts.
module im_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int AW        = 16
) (
  input logic              clk,
  input logic              rst_n,
  im_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_YIELD = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  state_t        state, state_nxt;
  logic [7:0]    burst_cnt, cnt_nxt;
  logic          fetch_gnt;
  logic          ld_gnt;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic          wr_en;
  logic [15:0]   wdata;

  assign fetch_gnt = bus.if_req &
                     (state == S_FETCH || state == S_YIELD);
  assign ld_gnt    = bus.ld_req & (state == S_LOAD);

  assign bus.ld_gnt    = ld_gnt;
  assign bus.if_stall  = bus.if_req & ~fetch_gnt;
  assign bus.mem_addr  = addr;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_wdata = wdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    unique case (state)
      S_FETCH: begin
        if (bus.ld_req) begin
          state_nxt = S_LOAD;
          cnt_nxt   = 8'd0;
        end
      end
      S_LOAD: begin
        if (!bus.ld_req) begin
          state_nxt = S_FETCH;
          cnt_nxt   = 8'd0;
        end else if (burst_cnt == CNT_MAX
                     && bus.if_req) begin
          state_nxt = S_YIELD;
          cnt_nxt   = 8'd0;
        end else if (burst_cnt != CNT_MAX) begin
          cnt_nxt = burst_cnt + 8'd1;
        end
      end
      S_YIELD: begin
        cnt_nxt   = 8'd0;
        state_nxt = bus.ld_req ? S_LOAD : S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Grants are mutually exclusive by state, so one mux suffices.
  always_comb begin
    addr  = bus.if_addr;
    rd_en = 1'b0;
    wr_en = 1'b0;
    wdata = 16'h0000;
    unique case (1'b1)
      fetch_gnt: rd_en = 1'b1;
      ld_gnt: begin
        addr  = bus.ld_addr;
        rd_en = ~bus.ld_we;
        wr_en = bus.ld_we;
        wdata = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_instr <= 16'h0000;
      bus.if_vld   <= 1'b0;
      bus.ld_rdata <= 16'h0000;
      bus.ld_vld   <= 1'b0;
    end else begin
      bus.if_vld <= fetch_gnt;
      if (fetch_gnt)
        bus.if_instr <= bus.mem_rdata;
      bus.ld_vld <= ld_gnt & ~bus.ld_we;
      if (ld_gnt && !bus.ld_we)
        bus.ld_rdata <= bus.mem_rdata;
    end
  end

endmodule
